cdb_rr_arbiter: RTL
===================

CDB_RR_ARBITER -- requirements
Module: cdb_rr_arbiter

Interface
REQ-001 The block SHALL provide parameter N_REQ, default 4, giving the number of reservation-station requesters (legal values 2..8).
REQ-002 The block SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL provide port flush, input, 1 bit: synchronous squash from the ROB on mispredict.
REQ-005 The block SHALL provide port rs_cdb_in[0:N_REQ-1], input, CDB each: per-requester broadcast request; .valid means the request is pending.
REQ-006 The block SHALL provide port rs_grant[0:N_REQ-1], output, 1 bit each: combinational grant; the requester dequeues its entry in the same cycle.
REQ-007 The block SHALL provide port cdb_out, output, CDB: registered bus broadcast.
REQ-008 The block SHALL provide port rr_ptr, output, clog2(N_REQ) bits: current highest-priority index, for debug and coverage.

Function
REQ-009 Arbitration SHALL be round-robin: scan indices rr_ptr, rr_ptr+1, ... modulo N_REQ; the first index with valid set wins.
REQ-010 At most one rs_grant bit SHALL be high in any cycle; rs_grant SHALL be all-zero when no input is valid.
REQ-011 A granted request SHALL appear on cdb_out exactly one cycle later, with all fields copied unchanged.
REQ-012 If no grant occurs in a cycle, cdb_out SHALL be all-zero (valid=0) in the next cycle.
REQ-013 On a grant to index g, rr_ptr SHALL become (g+1) mod N_REQ at the next edge; with no grant, rr_ptr SHALL hold.
REQ-014 Wrap-around: a grant to index N_REQ-1 SHALL set rr_ptr to 0.
REQ-015 While flush=1, rs_grant SHALL be all-zero, cdb_out SHALL be zero at the next edge, and rr_ptr SHALL hold.
REQ-016 Flush SHALL also squash any broadcast already registered: cdb_out is zero in the cycle after the flush cycle, whatever was granted before.
REQ-017 Requesters not granted SHALL keep their request valid and stable; the arbiter SHALL NOT drop or reorder them.
REQ-018 Under continuous requests from all N_REQ sources, each source SHALL be granted exactly once in every N_REQ consecutive cycles (no starvation).

Reset
REQ-019 While rst_n=0, cdb_out SHALL be all-zero, rr_ptr SHALL be 0, and rs_grant SHALL be all-zero, independent of clk.
REQ-020 Deassertion of rst_n SHALL take effect at the next rising clk edge; the first grant can occur in that cycle.
REQ-021 Reset asserted mid-broadcast SHALL discard the registered broadcast and SHALL produce no grant.

Structure
REQ-022 The CDB struct (valid, tag, data) SHALL come from the shared package lc3b_types; the block SHALL NOT redefine it.
REQ-023 The shared package SHALL hold the constants for CDB tag width and the default N_REQ.
REQ-024 The round-robin selection SHALL be a combinational sub-module rr_select (inputs: request vector and pointer; outputs: one-hot grant and a found flag), instantiated once.
REQ-025 The block SHALL contain only two state elements: the cdb_out register and the rr_ptr register.

Verification
REQ-026 Reset then single request: rs_cdb_in[2]={1,tag 5,0x1234} -> rs_grant[2]=1 in the same cycle; cdb_out={1,5,0x1234} next cycle; rr_ptr=3.
REQ-027 All four valid for 8 cycles from rr_ptr=0 -> grant order 0,1,2,3,0,1,2,3; cdb_out tags follow, each one cycle later.
REQ-028 rr_ptr=3 with requesters 1 and 3 valid -> grant 3, rr_ptr wraps to 0; next cycle requester 1 is granted and rr_ptr=2.
REQ-029 Flush in the cycle after a grant to 0, with requesters 1 and 2 valid -> no grant while flushing; cdb_out.valid=0 in the following cycle; rr_ptr unchanged; requester 1 is granted the cycle after the flush.
REQ-030 rst_n pulsed low asynchronously mid-cycle while cdb_out.valid=1 -> cdb_out=0 and rr_ptr=0 immediately; no grant until rst_n returns high.
REQ-031 No requests for 5 cycles -> rs_grant all-zero, cdb_out.valid=0, rr_ptr stable throughout.

Source files
------------

// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Package : lc3b_types
// Shared LC-3b core types: common data bus (CDB) record and sizing constants.
// Rev 1.0 : initial release
// ============================================================================
package lc3b_types;

  localparam int CDB_TAG_W         = 4;
  localparam int CDB_DATA_W        = 16;
  localparam int CDB_N_REQ_DEFAULT = 4;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_t;

endpackage : lc3b_types
`default_nettype wire

// File: rtl/cdb_rr_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
// Module  : rr_select
// Combinational round-robin picker: first asserted request at or after the
// pointer (modulo N_REQ) wins; produces a one-hot grant and a found flag.
// Rev 1.0 : initial release
// ============================================================================
module rr_select #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         grant_o,
  output logic                     found_o
);

  // Scan from the pointer and wrap; the first hit is the only grant.
  always_comb begin
    int idx;
    grant_o = '0;
    found_o = 1'b0;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr_i) + i) % N_REQ;
      if (!found_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found_o      = 1'b1;
      end
    end
  end

endmodule : rr_select
`default_nettype wire

// File: rtl/cdb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cdb_rr_arbiter
// Round-robin arbiter granting one reservation station per cycle access to
// the common data bus; the winner's record is broadcast one cycle later.
// Rev 1.0 : initial release
// ============================================================================
module cdb_rr_arbiter
  import lc3b_types::*;
#(
  parameter int N_REQ = CDB_N_REQ_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  cdb_t                     rs_cdb_in [0:N_REQ-1],
  output logic [N_REQ-1:0]         rs_grant,
  output cdb_t                     cdb_out,
  output logic [$clog2(N_REQ)-1:0] rr_ptr
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req_w;
  logic [N_REQ-1:0] grant_w;
  logic             found_w;
  cdb_t             cdb_d;
  cdb_t             cdb_q;
  logic [PTR_W-1:0] rr_ptr_d;
  logic [PTR_W-1:0] rr_ptr_q;

  // Requests are masked during flush and while reset is held, so no grant
  // can escape to a requester in either case (reset masking is clock-free).
  always_comb begin
    req_w = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_w[i] = rs_cdb_in[i].valid & rst_n & ~flush;
    end
  end

  rr_select #(
    .N_REQ (N_REQ)
  ) u_rr_select (
    .req_i   (req_w),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant_w),
    .found_o (found_w)
  );

  // Capture the winner's record and advance the pointer past it; with no
  // winner the bus goes idle and the pointer holds.
  always_comb begin
    cdb_d    = '0;
    rr_ptr_d = rr_ptr_q;
    if (found_w) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_w[i]) begin
          cdb_d    = rs_cdb_in[i];
          rr_ptr_d = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
        end
      end
    end
  end

  // Broadcast and pointer registers; the only state in the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      cdb_q    <= cdb_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rs_grant = grant_w;
  assign cdb_out  = cdb_q;
  assign rr_ptr   = rr_ptr_q;

endmodule : cdb_rr_arbiter
`default_nettype wire
